// File: rtl/signed_divider.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per
// clock, truncating toward zero. Divide-by-zero and MIN / -1 are resolved
// at accept time and finish after a single extra edge.
module signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (v[WIDTH-1]) begin
      res = ~v + ONE;
    end else begin
      res = v;
    end
    return res;
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             sign_x_r;
  logic             sign_y_r;
  logic [WIDTH-1:0] dvd_r;      // |x|, shifted out MSB first
  logic [WIDTH-1:0] dvs_r;      // |y|
  logic [WIDTH:0]   rem_r;      // partial remainder
  logic [WIDTH-1:0] quo_r;      // unsigned quotient being built
  logic             pend_ovf_r; // flags decided at accept, published at FIX
  logic             pend_dz_r;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // Restoring step datapath and final sign correction.
  always_comb begin
    trial_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    diff_s  = trial_s - {1'b0, dvs_r};
    ge_s    = (trial_s >= {1'b0, dvs_r});
    q_fix_s = quo_r;
    r_fix_s = rem_r[WIDTH-1:0];
    if (sign_x_r ^ sign_y_r) begin
      q_fix_s = ~quo_r + ONE;
    end else begin
      q_fix_s = quo_r;
    end
    if (sign_x_r) begin
      r_fix_s = ~rem_r[WIDTH-1:0] + ONE;
    end else begin
      r_fix_s = rem_r[WIDTH-1:0];
    end
  end

  // Control FSM, iteration state and registered results/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      sign_x_r   <= 1'b0;
      sign_y_r   <= 1'b0;
      dvd_r      <= {WIDTH{1'b0}};
      dvs_r      <= {WIDTH{1'b0}};
      rem_r      <= {(WIDTH+1){1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      pend_ovf_r <= 1'b0;
      pend_dz_r  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      q          <= {WIDTH{1'b0}};
      r          <= {WIDTH{1'b0}};
      overflow   <= 1'b0;
      negative   <= 1'b0;
      zero       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            cnt_r      <= {CW{1'b0}};
            dvd_r      <= abs_val(x);
            dvs_r      <= abs_val(y);
            sign_x_r   <= x[WIDTH-1];
            sign_y_r   <= y[WIDTH-1];
            pend_ovf_r <= 1'b0;
            pend_dz_r  <= 1'b0;
            quo_r      <= {WIDTH{1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            if (y == {WIDTH{1'b0}}) begin
              // Preload the final answer; cleared signs make FIX pass it through.
              pend_dz_r <= 1'b1;
              quo_r     <= ALL_ONES;
              rem_r     <= {1'b0, x};
              sign_x_r  <= 1'b0;
              sign_y_r  <= 1'b0;
              state_r   <= FIX;
            end else if ((x == MIN_VAL) && (y == ALL_ONES)) begin
              pend_ovf_r <= 1'b1;
              quo_r      <= MIN_VAL;
              sign_x_r   <= 1'b0;
              sign_y_r   <= 1'b0;
              state_r    <= FIX;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          if (ge_s) begin
            rem_r <= diff_s;
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= trial_s;
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          q        <= q_fix_s;
          r        <= r_fix_s;
          negative <= q_fix_s[WIDTH-1];
          zero     <= (q_fix_s == {WIDTH{1'b0}});
          overflow <= pend_ovf_r;
          div_zero <= pend_dz_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          cnt_r    <= {CW{1'b0}};
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider (WIDTH=8) with a queue scoreboard.
module tb_signed_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       overflow;
  logic       negative;
  logic       zero;
  logic       div_zero;

  signed_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .q(q), .r(r),
    .overflow(overflow), .negative(negative), .zero(zero), .div_zero(div_zero)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       neg;
    logic       zr;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: SV integer division already truncates toward zero.
  task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int xi, yi, qi, ri;
    xi = int'($signed(a));
    yi = int'($signed(b));
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (yi == 0) begin
      qi = -1; ri = xi; e.dz = 1'b1; e.lat = 1;
    end else if (xi == -128 && yi == -1) begin
      qi = -128; ri = 0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      qi = xi / yi; ri = xi % yi; e.lat = 9;
    end
    e.q = qi[7:0];
    e.r = ri[7:0];
    e.neg = qi[7];
    e.zr = (qi[7:0] == 8'd0);
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    push_exp(a, b);
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Returns at the falling edge inside the done cycle.
  task automatic wait_done();
    exp_t e;
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    check("done_seen", done, 1);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - acc, e.lat);
        check("q", q, e.q);
        check("r", r, e.r);
        check("overflow", overflow, e.ovf);
        check("negative", negative, e.neg);
        check("zero", zero, e.zr);
        check("div_zero", div_zero, e.dz);
        check("busy_at_done", busy, 0);
      end
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; x = 8'd0; y = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_flags", {overflow, negative, zero, div_zero}, 0);
    rst_n = 1'b1;

    // Basic case and done pulse width.
    start_op(8'd100, 8'd7);
    wait_done();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("q_held", q, 8'h0E);

    // Sign combinations and boundary values.
    start_op(8'h9C, 8'd7);   wait_done();
    start_op(8'h9C, 8'hF9);  wait_done();
    start_op(8'd7, 8'h9C);   wait_done();
    start_op(8'h80, 8'd1);   wait_done();
    start_op(8'h80, 8'hFF);  wait_done();
    start_op(8'd5, 8'd0);    wait_done();
    start_op(8'h80, 8'h80);  wait_done();
    start_op(8'h7F, 8'h80);  wait_done();
    for (int i = 0; i < 6; i++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done();
    end

    // start during CALC is ignored; start in the done cycle is accepted.
    start_op(8'd100, 8'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = 8'd1; y = 8'd1; start = (i % 2 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done();
    x = 8'd9; y = 8'd3; start = 1'b1;
    push_exp(8'd9, 8'd3);
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    check("busy_b2b", busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_q", q, 8'd14);
      check("hold_r", r, 8'd2);
    end
    wait_done();

    // Asynchronous reset in the middle of CALC.
    start_op(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", q, 0);
    check("arst_r", r, 0);
    check("arst_flags", {overflow, negative, zero, div_zero}, 0);
    #7;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("no_spurious_done", seen, 0);
    start_op(8'd50, 8'hFA);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
